sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, meaning clk100 cycles of active strobe per SRAM access (legal 1..7).
REQ-002 SHALL have parameter MAX_VID_BURST, default 8, meaning consecutive video grants allowed while a host request waits (legal 1..255).
REQ-003 SHALL have port clk100  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports vid_req in 1 / vid_addr in 18  video read request and word address, held stable until vid_ack.
REQ-006 SHALL have ports vid_ack out 1 / vid_rdata out 16 / vid_rvalid out 1  video accept pulse, read data, data-valid pulse.
REQ-007 SHALL have ports host_req in 1 / host_we in 1 / host_addr in 18 / host_wdata in 16 / host_be in 2  host request, held stable until host_ack; be[0]=low byte, be[1]=high byte.
REQ-008 SHALL have ports host_ack out 1 / host_rdata out 16 / host_rvalid out 1  host accept pulse, read data, data-valid pulse (reads only).
REQ-009 SHALL have ports ram_addr out 18 / ram_din in 16 / ram_dout out 16 / ram_ce, ram_oe, ram_we, ram_lb, ram_hb out 1  active-high SRAM strobes; the top level inverts them and drives the bus while ram_we=1.

Function
REQ-010 SHALL be an FSM with states IDLE, RD, WR_SETUP, WR_PULSE, WR_RECOVER; all ram_* outputs registered.
REQ-011 SHALL arbitrate only in IDLE; grant = video if vid_req and not (host_req and burst_cnt==MAX_VID_BURST), else host if host_req.
REQ-012 SHALL pulse the granted ack for exactly one cycle (cycle T) and capture address/data/be/we in T; ack never asserts outside IDLE.
REQ-013 SHALL increment burst_cnt (8 bits, saturating at MAX_VID_BURST) on each video grant while host_req=1, and clear it on any host grant or any cycle with host_req=0.
REQ-014 SHALL, for a read, assert ram_ce, ram_oe, ram_lb, ram_hb (video: both bytes; host: per host_be) in cycles T+1..T+ACCESS_CYCLES, sample ram_din at the end of T+ACCESS_CYCLES, and present rdata with a one-cycle rvalid to the owning requester in T+ACCESS_CYCLES+1.
REQ-015 SHALL, for a write, assert ram_ce with ram_we=0 in T+1 (WR_SETUP), ram_ce, ram_we, byte lanes per host_be and ram_dout=wdata in T+2..T+1+ACCESS_CYCLES (WR_PULSE), and all strobes 0 in T+2+ACCESS_CYCLES (WR_RECOVER).
REQ-016 SHALL return to IDLE the cycle after the last RD or WR_RECOVER cycle; earliest next ack is that IDLE cycle (read period ACCESS_CYCLES+1, write period ACCESS_CYCLES+3).
REQ-017 SHALL hold ram_addr stable across an entire access and never assert ram_oe and ram_we together.
REQ-018 SHALL keep ram_oe=ram_we=ram_ce=0 and ram_dout=0 in IDLE.
REQ-019 SHALL treat host_be=2'b00 as a legal access that runs full timing with ram_lb=ram_hb=0.
REQ-020 SHALL ignore vid_req/host_req deassertion after ack; a started access always completes.
REQ-021 SHALL hold vid_rdata/host_rdata at their last value between rvalid pulses.

Reset
REQ-022 SHALL on reset assertion immediately force state IDLE, all ram_* outputs 0, acks and rvalids 0, rdata 0, burst_cnt 0, aborting any access mid-cycle.
REQ-023 SHALL grant nothing in the first cycle after reset deasserts; arbitration begins the following cycle.

Structure
REQ-024 SHALL place the state enum, SRAM address width (18) and data width (16) in shared package video_pkg.
REQ-025 SHALL be a single module with no sub-modules; the burst counter and access-cycle counter are local.

Verification
REQ-026 SHALL test isolated host read 0x00010, be=11, ACCESS_CYCLES=2 -> ack at T, ce/oe high T+1..T+2, host_rvalid at T+3 with model word.
REQ-027 SHALL test host write 0x3FFFF=0xA55A, be=01 -> WR_SETUP T+1, we/lb high hb low T+2..T+3, recover T+4, model updates low byte only.
REQ-028 SHALL test vid_req and host_req constantly high, MAX_VID_BURST=8 -> pattern of 8 video grants then 1 host grant repeating; burst_cnt never exceeds 8.
REQ-029 SHALL test simultaneous first request from both -> video granted first; host granted immediately after if vid_req drops.
REQ-030 SHALL test reset asserted during WR_PULSE -> ram_we/ram_ce low the same cycle (asynchronous), no rvalid, no ack until two cycles after release.
REQ-031 SHALL check every cycle by assertion: never oe&we, ram_addr constant within an access, acks one-hot and single-cycle.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the SRAM arbiter: access FSM states and SRAM bus widths.
package video_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_RECOVER
  } state_t;
endpackage

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between a video read port and a host read/write port.
// Video wins arbitration unless the host has waited out MAX_VID_BURST video grants; all SRAM strobes are registered.
module sram_arbiter
  import video_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_VID_BURST = 8
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [1:0]        host_be,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_din,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ram_lb,
  output logic              ram_hb
);
  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_VID_BURST);
  localparam logic [2:0] LP_LAST      = 3'(ACCESS_CYCLES - 1);

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic [7:0]          r_burst;
  logic                r_arb_en;
  logic                r_owner_host;
  logic [1:0]          r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_dout;
  logic                r_ce, r_oe, r_we, r_lb, r_hb;
  logic [DATA_W-1:0]   r_vid_rdata, r_host_rdata;
  logic                r_vid_rvalid, r_host_rvalid;
  logic                w_grant_vid, w_grant_host;
  logic [1:0]          w_lanes;
  logic                w_rd_done;

  // r_arb_en keeps the first cycle after reset release grant-free.
  always_comb begin
    w_grant_vid  = 1'b0;
    w_grant_host = 1'b0;
    if (r_state == ST_IDLE && r_arb_en) begin
      if (vid_req && !(host_req && r_burst == LP_MAX_BURST)) w_grant_vid = 1'b1;
      else if (host_req)                                     w_grant_host = 1'b1;
    end
  end

  always_comb begin
    w_lanes = r_be;
    if (w_grant_host)     w_lanes = host_be;
    else if (w_grant_vid) w_lanes = 2'b11;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 3'd0;
        if (w_grant_vid || (w_grant_host && !host_we)) w_state_nxt = ST_RD;
        else if (w_grant_host)                         w_state_nxt = ST_WR_SETUP;
      end
      ST_RD: begin
        if (r_cnt == LP_LAST) w_state_nxt = ST_IDLE;
        else                  w_cnt_nxt   = r_cnt + 3'd1;
      end
      ST_WR_SETUP: begin
        w_state_nxt = ST_WR_PULSE;
        w_cnt_nxt   = 3'd0;
      end
      ST_WR_PULSE: begin
        if (r_cnt == LP_LAST) w_state_nxt = ST_WR_RECOVER;
        else                  w_cnt_nxt   = r_cnt + 3'd1;
      end
      ST_WR_RECOVER: w_state_nxt = ST_IDLE;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_rd_done = (r_state == ST_RD) && (r_cnt == LP_LAST);

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 3'd0;
      r_burst       <= 8'd0;
      r_arb_en      <= 1'b0;
      r_owner_host  <= 1'b0;
      r_be          <= 2'b00;
      r_wdata       <= '0;
      r_addr        <= '0;
      r_dout        <= '0;
      r_ce          <= 1'b0;
      r_oe          <= 1'b0;
      r_we          <= 1'b0;
      r_lb          <= 1'b0;
      r_hb          <= 1'b0;
      r_vid_rdata   <= '0;
      r_host_rdata  <= '0;
      r_vid_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_arb_en <= 1'b1;

      // Request fields are frozen at grant so ram_addr holds for the whole access.
      if (w_grant_vid || w_grant_host) begin
        r_addr       <= w_grant_host ? host_addr : vid_addr;
        r_be         <= w_lanes;
        r_wdata      <= host_wdata;
        r_owner_host <= w_grant_host;
      end

      if (!host_req || w_grant_host)                 r_burst <= 8'd0;
      else if (w_grant_vid && r_burst != LP_MAX_BURST) r_burst <= r_burst + 8'd1;

      r_ce <= (w_state_nxt == ST_RD) || (w_state_nxt == ST_WR_SETUP) || (w_state_nxt == ST_WR_PULSE);
      r_oe <= (w_state_nxt == ST_RD);
      r_we <= (w_state_nxt == ST_WR_PULSE);
      {r_hb, r_lb} <= ((w_state_nxt == ST_RD) || (w_state_nxt == ST_WR_PULSE)) ? w_lanes : 2'b00;
      r_dout <= (w_state_nxt == ST_WR_PULSE) ? r_wdata : '0;

      r_vid_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      if (w_rd_done) begin
        if (r_owner_host) begin
          r_host_rdata  <= ram_din;
          r_host_rvalid <= 1'b1;
        end else begin
          r_vid_rdata  <= ram_din;
          r_vid_rvalid <= 1'b1;
        end
      end
    end
  end

  assign vid_ack     = w_grant_vid;
  assign host_ack    = w_grant_host;
  assign vid_rdata   = r_vid_rdata;
  assign vid_rvalid  = r_vid_rvalid;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;
  assign ram_addr    = r_addr;
  assign ram_dout    = r_dout;
  assign ram_ce      = r_ce;
  assign ram_oe      = r_oe;
  assign ram_we      = r_we;
  assign ram_lb      = r_lb;
  assign ram_hb      = r_hb;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM emulation, a cycle-schedule reference model, directed cases and random traffic.
module tb_sram_arbiter;
  import video_pkg::*;

  localparam int AC  = 2;
  localparam int MXB = 8;

  logic              clk100 = 1'b0;
  logic              reset;
  logic              vid_req, host_req, host_we;
  logic [ADDR_W-1:0] vid_addr, host_addr, ram_addr;
  logic [DATA_W-1:0] host_wdata, vid_rdata, host_rdata, ram_din, ram_dout;
  logic [1:0]        host_be;
  logic              vid_ack, vid_rvalid, host_ack, host_rvalid;
  logic              ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

  sram_arbiter #(.ACCESS_CYCLES(AC), .MAX_VID_BURST(MXB)) dut (
    .clk100(clk100), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_be(host_be), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb)
  );

  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int rst_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // SRAM emulation: untouched words read as addr[15:0]^BEEF.
  logic [DATA_W-1:0] env_mem [0:262143];
  bit                env_vld [0:262143];
  assign ram_din = !ram_oe ? 16'h0 :
                   (env_vld[ram_addr] ? env_mem[ram_addr] : (ram_addr[15:0] ^ 16'hBEEF));
  always @(posedge clk100) begin
    if (ram_we) begin
      env_mem[ram_addr] <= {ram_hb ? ram_dout[15:8] : ram_din_cur(ram_addr, 1'b1),
                            ram_lb ? ram_dout[7:0]  : ram_din_cur(ram_addr, 1'b0)};
      env_vld[ram_addr] <= 1'b1;
    end
  end
  function automatic logic [7:0] ram_din_cur(input logic [17:0] a, input bit hi);
    logic [15:0] w;
    w = env_vld[a] ? env_mem[a] : (a[15:0] ^ 16'hBEEF);
    return hi ? w[15:8] : w[7:0];
  endfunction

  // Reference model: each grant writes the expected bus picture into future cycle slots.
  typedef struct {
    logic ce, oe, we, lb, hb, chk_addr, vrv, hrv;
    logic [17:0] addr;
    logic [15:0] dout, rdata;
  } exp_t;
  exp_t        ring [16];
  logic [15:0] model_mem [0:262143];
  int          busy_until, m_burst;
  logic [15:0] exp_vrd, exp_hrd;

  function automatic exp_t blank();
    exp_t e;
    e.ce = 0; e.oe = 0; e.we = 0; e.lb = 0; e.hb = 0; e.chk_addr = 0; e.vrv = 0; e.hrv = 0;
    e.addr = '0; e.dout = '0; e.rdata = '0;
    return e;
  endfunction

  task automatic sched_read(input int c, input logic [17:0] a, input logic [1:0] l, input bit host);
    exp_t e;
    for (int k = 1; k <= AC; k++) begin
      e = blank(); e.ce = 1; e.oe = 1; e.lb = l[0]; e.hb = l[1]; e.chk_addr = 1; e.addr = a;
      ring[(c + k) % 16] = e;
    end
    e = blank(); e.vrv = !host; e.hrv = host; e.rdata = model_mem[a];
    ring[(c + AC + 1) % 16] = e;
    busy_until = c + AC + 1;
  endtask

  task automatic sched_write(input int c, input logic [17:0] a, input logic [15:0] d, input logic [1:0] l);
    exp_t e;
    e = blank(); e.ce = 1; e.chk_addr = 1; e.addr = a;
    ring[(c + 1) % 16] = e;
    for (int k = 2; k <= AC + 1; k++) begin
      e = blank(); e.ce = 1; e.we = 1; e.lb = l[0]; e.hb = l[1]; e.dout = d; e.chk_addr = 1; e.addr = a;
      ring[(c + k) % 16] = e;
    end
    e = blank(); e.chk_addr = 1; e.addr = a;
    ring[(c + AC + 2) % 16] = e;
    if (l[0]) model_mem[a][7:0]  = d[7:0];
    if (l[1]) model_mem[a][15:8] = d[15:8];
    busy_until = c + AC + 3;
  endtask

  initial begin
    exp_t e;
    int   slot;
    bit   free, g_v, g_h;
    for (int i = 0; i < 262144; i++) model_mem[i] = 16'(i) ^ 16'hBEEF;
    for (int i = 0; i < 16; i++) ring[i] = blank();
    busy_until = 0; m_burst = 0; exp_vrd = '0; exp_hrd = '0;
    forever begin
      @(negedge clk100);
      slot = cyc % 16;
      if (reset) begin
        for (int i = 0; i < 16; i++) ring[i] = blank();
        busy_until = 0; m_burst = 0; exp_vrd = '0; exp_hrd = '0;
        chk("rst_strobes", {ram_ce, ram_oe, ram_we, ram_lb, ram_hb, vid_ack, host_ack, vid_rvalid, host_rvalid}, 0);
        chk("rst_dout", ram_dout, 0);
        chk("rst_rdata", {vid_rdata, host_rdata}, 0);
      end else begin
        e = ring[slot];
        if (e.vrv) exp_vrd = e.rdata;
        if (e.hrv) exp_hrd = e.rdata;
        chk("ram_ce", ram_ce, e.ce);
        chk("ram_oe", ram_oe, e.oe);
        chk("ram_we", ram_we, e.we);
        chk("ram_lanes", {ram_hb, ram_lb}, {e.hb, e.lb});
        chk("ram_dout", ram_dout, e.dout);
        chk("vid_rvalid", vid_rvalid, e.vrv);
        chk("host_rvalid", host_rvalid, e.hrv);
        chk("vid_rdata", vid_rdata, exp_vrd);
        chk("host_rdata", host_rdata, exp_hrd);
        if (e.chk_addr) chk("ram_addr", ram_addr, e.addr);
        chk("oe_we_excl", ram_oe & ram_we, 0);
        ring[slot] = blank();
        free = (cyc >= busy_until) && (cyc > rst_cyc);
        g_v  = free && vid_req && !(host_req && m_burst == MXB);
        g_h  = free && !g_v && host_req;
        chk("vid_ack", vid_ack, g_v);
        chk("host_ack", host_ack, g_h);
        if (g_v) sched_read(cyc, vid_addr, 2'b11, 1'b0);
        else if (g_h && host_we) sched_write(cyc, host_addr, host_wdata, host_be);
        else if (g_h) sched_read(cyc, host_addr, host_be, 1'b1);
        if (!host_req || g_h) m_burst = 0;
        else if (g_v && m_burst < MXB) m_burst++;
      end
    end
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic wait_ack(input bit host, input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk100);
      if (host ? host_ack : vid_ack) break;
    end
    chk(nm, host ? host_ack : vid_ack, 1);
  endtask

  task automatic host_go(input bit we, input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
    tick();
    host_req = 1; host_we = we; host_addr = a; host_wdata = d; host_be = be;
  endtask

  task automatic vid_agent(input int n);
    bit acked = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk100); #1;
      if (!vid_req || acked) begin
        vid_req  = ($urandom_range(0, 3) != 0);
        vid_addr = 18'($urandom_range(0, 63));
      end
      @(negedge clk100);
      acked = vid_ack;
    end
  endtask

  task automatic host_agent(input int n);
    bit acked = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk100); #1;
      if (!host_req || acked) begin
        host_req   = ($urandom_range(0, 1) != 0);
        host_we    = ($urandom_range(0, 1) != 0);
        host_addr  = 18'($urandom_range(0, 63));
        host_wdata = 16'($urandom);
        host_be    = 2'($urandom_range(0, 3));
      end
      @(negedge clk100);
      acked = host_ack;
    end
  endtask

  initial begin
    int run, nhost;
    reset = 1; vid_req = 0; vid_addr = '0; host_req = 0; host_we = 0;
    host_addr = '0; host_wdata = '0; host_be = 2'b00;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    chk("reset_ram", {ram_ce, ram_oe, ram_we, ram_dout}, 0);
    chk("reset_acks", {vid_ack, host_ack, vid_rvalid, host_rvalid}, 0);

    // Simultaneous first requests right at reset release.
    tick();
    reset = 0; rst_cyc = cyc;
    vid_req = 1; vid_addr = 18'h00005;
    host_req = 1; host_we = 0; host_addr = 18'h00010; host_be = 2'b11;
    @(negedge clk100); chk("first_cycle_no_grant", {vid_ack, host_ack}, 0);
    @(negedge clk100); chk("first_vid_grant", {vid_ack, host_ack}, 2'b10);
    tick(); vid_req = 0;
    @(negedge clk100); chk("host_wait1", host_ack, 0);
    @(negedge clk100); chk("host_wait2", host_ack, 0);
    @(negedge clk100); chk("host_after_vid", host_ack, 1);
    tick(); host_req = 0;
    repeat (5) tick();

    // Isolated host read of 0x00010.
    host_go(0, 18'h00010, 16'h0, 2'b11);
    wait_ack(1, "rd_ack");
    tick(); host_req = 0;
    @(negedge clk100); chk("rd_t1_ce_oe_we", {ram_ce, ram_oe, ram_we}, 3'b110); chk("rd_t1_addr", ram_addr, 18'h00010);
    @(negedge clk100); chk("rd_t2_ce_oe", {ram_ce, ram_oe, ram_lb, ram_hb}, 4'b1111);
    @(negedge clk100); chk("rd_t3_rvalid", host_rvalid, 1); chk("rd_t3_data", host_rdata, 16'hBEFF);
    chk("rd_t3_ce", ram_ce, 0);

    // Host write 0x3FFFF=0xA55A, low byte only, then read back.
    host_go(1, 18'h3FFFF, 16'hA55A, 2'b01);
    wait_ack(1, "wr_ack");
    tick(); host_req = 0;
    @(negedge clk100); chk("wr_setup", {ram_ce, ram_oe, ram_we}, 3'b100);
    @(negedge clk100); chk("wr_pulse1", {ram_ce, ram_we, ram_lb, ram_hb}, 4'b1110); chk("wr_dout", ram_dout, 16'hA55A);
    @(negedge clk100); chk("wr_pulse2", {ram_ce, ram_we, ram_lb, ram_hb}, 4'b1110);
    @(negedge clk100); chk("wr_recover", {ram_ce, ram_oe, ram_we, ram_lb, ram_hb}, 0); chk("wr_rec_addr", ram_addr, 18'h3FFFF);
    host_go(0, 18'h3FFFF, 16'h0, 2'b11);
    wait_ack(1, "rb_ack");
    tick(); host_req = 0;
    repeat (3) @(negedge clk100);
    chk("rb_rvalid", host_rvalid, 1); chk("rb_data", host_rdata, 16'h415A);

    // be=00 write runs full timing with no lanes.
    host_go(1, 18'h00020, 16'h1234, 2'b00);
    wait_ack(1, "be0_ack");
    tick(); host_req = 0;
    @(negedge clk100);
    @(negedge clk100); chk("be0_pulse", {ram_ce, ram_we, ram_lb, ram_hb}, 4'b1100);
    @(negedge clk100); chk("be0_pulse2", ram_we, 1);
    host_go(0, 18'h00020, 16'h0, 2'b11);
    wait_ack(1, "be0_rb_ack");
    tick(); host_req = 0;
    repeat (3) @(negedge clk100);
    chk("be0_rb_data", host_rdata, 16'hBECF);

    // Reset landing in the middle of a write pulse.
    host_go(1, 18'h2AAAA, 16'hFFFF, 2'b11);
    wait_ack(1, "abort_ack");
    tick(); host_req = 0;
    tick(); #1;
    chk("abort_we_before", ram_we, 1);
    reset = 1;
    #1;
    chk("abort_async_we_ce", {ram_we, ram_ce}, 0);
    host_req = 1; host_we = 0; host_addr = 18'h00010; host_be = 2'b11;
    @(negedge clk100); chk("abort_no_rvalid", host_rvalid, 0);
    tick(); reset = 0; rst_cyc = cyc;
    @(negedge clk100); chk("abort_no_ack_first", host_ack, 0);
    @(negedge clk100); chk("abort_ack_second", host_ack, 1);
    tick(); host_req = 0;
    repeat (5) tick();

    // Both requesters held high: runs of MXB video grants between host grants.
    vid_req = 1; vid_addr = 18'h00005;
    host_req = 1; host_we = 0; host_addr = 18'h00010; host_be = 2'b11;
    run = 0; nhost = 0;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk100);
      if (vid_ack) run++;
      if (host_ack) begin
        chk("burst_run", run, MXB);
        nhost++;
        run = 0;
      end
    end
    chk("burst_host_grants", (nhost >= 3) ? 1 : 0, 1);
    tick(); vid_req = 0; host_req = 0;
    repeat (6) tick();

    fork
      vid_agent(1500);
      host_agent(1500);
    join
    tick(); vid_req = 0; host_req = 0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
